// File: rtl/demux8_pkg.sv
// Shared types and helpers for the 8-slot write demultiplexer.
// Imported by the slot sub-module and the demux8_reg top.
package demux8_pkg;

    localparam int unsigned NUM_SLOTS = 8;

    typedef logic [2:0] slot_sel_t;
    typedef logic [3:0] occ_count_t;

    function automatic occ_count_t popcount8(input logic [NUM_SLOTS-1:0] v);
        occ_count_t n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + occ_count_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/demux8_slot.sv
// One holding slot: a data register plus its valid flag.
// A write wins over an ack, so drain-and-refill in one cycle leaves the slot valid.
module demux8_slot #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             ack,
    input  logic [width-1:0] d,
    output logic [width-1:0] q,
    output logic             valid
);

    logic [width-1:0] q_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else if (wr_en) begin
            q_q     <= d;
            valid_q <= 1'b1;
        end else if (ack) begin
            // Data is left stale on consumption.
            valid_q <= 1'b0;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;

endmodule

// File: rtl/demux8_reg.sv
// Routes one producer word into one of eight holding slots with per-slot backpressure.
// Holds the select decode, the in_ready mux and the registered occupancy counter.
module demux8_reg
    import demux8_pkg::*;
#(
    parameter int unsigned width = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  slot_sel_t            sel,
    input  logic [width-1:0]     in_data,
    output logic [width-1:0]     a,
    output logic [width-1:0]     b,
    output logic [width-1:0]     c,
    output logic [width-1:0]     d,
    output logic [width-1:0]     e,
    output logic [width-1:0]     f,
    output logic [width-1:0]     g,
    output logic [width-1:0]     h,
    output logic [NUM_SLOTS-1:0] out_valid,
    input  logic [NUM_SLOTS-1:0] out_ack,
    output occ_count_t           count,
    output logic                 full,
    output logic                 empty
);

    logic                 fire;
    logic [NUM_SLOTS-1:0] wr_en;
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [NUM_SLOTS-1:0] eff_ack;
    logic [width-1:0]     slot_q [NUM_SLOTS];
    occ_count_t           count_q;
    occ_count_t           count_d;

    // A full slot being acked this cycle can take a new word in the same cycle.
    assign in_ready = ~slot_valid[sel] | out_ack[sel];
    assign fire     = in_valid & in_ready;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            wr_en[i] = fire && (sel == slot_sel_t'(i));
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        demux8_slot #(
            .width(width)
        ) u_slot (
            .clk  (clk),
            .reset(reset),
            .wr_en(wr_en[i]),
            .ack  (out_ack[i]),
            .d    (in_data),
            .q    (slot_q[i]),
            .valid(slot_valid[i])
        );
    end

    // Acks on empty slots do not count; eff_ack is a subset of slot_valid so no underflow.
    assign eff_ack = out_ack & slot_valid;

    always_comb begin
        count_d = count_q - popcount8(eff_ack) + occ_count_t'(fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign a = slot_q[0];
    assign b = slot_q[1];
    assign c = slot_q[2];
    assign d = slot_q[3];
    assign e = slot_q[4];
    assign f = slot_q[5];
    assign g = slot_q[6];
    assign h = slot_q[7];

    assign out_valid = slot_valid;
    assign count     = count_q;
    assign full      = (count_q == occ_count_t'(NUM_SLOTS));
    assign empty     = (count_q == '0);

endmodule

// File: tb/tb_demux8_reg.sv
// Self-checking bench for demux8_reg: directed scenarios plus a randomized run
// against a slot-array reference model.
module tb_demux8_reg;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   sel;
    logic [W-1:0] in_data;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    logic [7:0]   out_valid;
    logic [7:0]   out_ack;
    logic [3:0]   count;
    logic         full;
    logic         empty;

    logic [W-1:0] outs [8];
    assign outs[0] = a;
    assign outs[1] = b;
    assign outs[2] = c;
    assign outs[3] = d;
    assign outs[4] = e;
    assign outs[5] = f;
    assign outs[6] = g;
    assign outs[7] = h;

    int total = 0;
    int bad   = 0;

    // Reference model: what each slot holds and whether it is occupied.
    logic [W-1:0] md [8];
    logic [7:0]   mv;

    demux8_reg #(
        .width(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .in_data  (in_data),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .f        (f),
        .g        (g),
        .h        (h),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    function automatic logic model_ready();
        return !mv[sel] || out_ack[sel];
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(mv[i]);
        return n;
    endfunction

    // Advance the model with the inputs present at the coming edge, then step past it.
    task automatic tick();
        logic rdy;
        if (reset) begin
            mv = 8'h00;
            for (int i = 0; i < 8; i++) md[i] = '0;
        end else begin
            rdy = model_ready();
            mv  = mv & ~out_ack;
            if (in_valid && rdy) begin
                md[sel] = in_data;
                mv[sel] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; sel = 3'd0; in_data = '0; out_ack = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_valid: got %h expected 00", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", empty, full); end
        total++; if (a !== '0 || h !== '0) begin bad++; $display("FAIL reset_data: got a=%h h=%h expected 0", a, h); end
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready sel=%0d: got %b expected 1", s, in_ready); end
        end
        sel = 3'd0;
    endtask

    task automatic test_fill();
        for (int s = 0; s < 8; s++) begin
            in_valid = 1'b1; sel = 3'(s); in_data = W'(16'h1111 * (s + 1));
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready sel=%0d: got %b expected 1", s, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 8'hFF) begin bad++; $display("FAIL fill_valid: got %h expected ff", out_valid); end
        total++; if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL fill_count: got %0d full=%b empty=%b expected 8 1 0", count, full, empty); end
        for (int s = 0; s < 8; s++) begin
            total++; if (outs[s] !== W'(16'h1111 * (s + 1))) begin bad++; $display("FAIL fill_data slot=%0d: got %h expected %h", s, outs[s], W'(16'h1111 * (s + 1))); end
        end
        in_valid = 1'b1; sel = 3'd3; in_data = 16'h9999;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_blocked_ready: got %b expected 0", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (d !== 16'h4444) begin bad++; $display("FAIL fill_blocked_data: got %h expected 4444", d); end
    endtask

    task automatic test_drain_refill();
        out_ack = 8'h04; in_valid = 1'b1; sel = 3'd2; in_data = 16'hAAAA;
        tick();
        in_data = 16'hBBBB;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL refill_ready: got %b expected 1", in_ready); end
        tick();
        out_ack = 8'h00; in_valid = 1'b0;
        total++; if (c !== 16'hBBBB) begin bad++; $display("FAIL refill_data: got %h expected bbbb", c); end
        total++; if (out_valid !== 8'hFF || count !== 4'd8) begin bad++; $display("FAIL refill_state: got valid=%h count=%0d expected ff 8", out_valid, count); end
    endtask

    task automatic test_multi_ack();
        out_ack = 8'hF0; in_valid = 1'b1; sel = 3'd0; in_data = 16'h5A5A;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL multi_ready: got %b expected 0", in_ready); end
        tick();
        out_ack = 8'h00;
        total++; if (out_valid !== 8'h0F || count !== 4'd4) begin bad++; $display("FAIL multi_state: got valid=%h count=%0d expected 0f 4", out_valid, count); end
        for (int k = 0; k < 2; k++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL multi_hold_ready: got %b expected 0", in_ready); end
            tick();
        end
        total++; if (a !== 16'h1111) begin bad++; $display("FAIL multi_hold_data: got %h expected 1111", a); end
        out_ack = 8'h01;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL multi_ack0_ready: got %b expected 1", in_ready); end
        tick();
        out_ack = 8'h00; in_valid = 1'b0;
        total++; if (a !== 16'h5A5A || out_valid !== 8'h0F || count !== 4'd4) begin bad++; $display("FAIL multi_refill: got a=%h valid=%h count=%0d expected 5a5a 0f 4", a, out_valid, count); end
    endtask

    task automatic test_idle_ack();
        out_ack = 8'h08;
        tick();
        out_ack = 8'h20;
        tick();
        out_ack = 8'h00;
        total++; if (count !== 4'd3 || out_valid !== 8'h07) begin bad++; $display("FAIL idle_ack: got count=%0d valid=%h expected 3 07", count, out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ack = 8'hFF;
        tick();
        out_ack = 8'h00; in_valid = 1'b1; sel = 3'd1; in_data = 16'h1234;
        tick();
        sel = 3'd6; in_data = 16'h6789;
        tick();
        total++; if (out_valid !== 8'h42 || count !== 4'd2) begin bad++; $display("FAIL midflight_pre: got valid=%h count=%0d expected 42 2", out_valid, count); end
        reset = 1'b1; sel = 3'd4; in_data = 16'h7777;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 8'h00 || count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL midflight_reset: got valid=%h count=%0d empty=%b expected 00 0 1", out_valid, count, empty); end
        total++; if (e !== '0 || b !== '0) begin bad++; $display("FAIL midflight_data: got e=%h b=%h expected 0 0", e, b); end
    endtask

    task automatic test_random();
        logic pending = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                pending  = 1'b1;
                sel      = 3'($urandom_range(0, 7));
                in_data  = W'($urandom);
            end
            in_valid = pending;
            if (!pending) sel = 3'($urandom_range(0, 7));
            out_ack = 8'($urandom) & 8'($urandom);
            reset   = ($urandom_range(0, 99) == 0);
            #1;
            total++; if (in_ready !== model_ready()) begin bad++; $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, in_ready, model_ready()); end
            if (reset || (in_valid && model_ready())) pending = 1'b0;
            tick();
            reset = 1'b0;
            total++; if (out_valid !== mv) begin bad++; $display("FAIL rand_valid cyc=%0d: got %h expected %h", cyc, out_valid, mv); end
            total++; if (int'(count) !== model_count()) begin bad++; $display("FAIL rand_count cyc=%0d: got %0d expected %0d", cyc, count, model_count()); end
            total++; if (int'(count) !== $countones(out_valid)) begin bad++; $display("FAIL rand_popcount cyc=%0d: got %0d expected %0d", cyc, count, $countones(out_valid)); end
            total++; if (full !== (model_count() == 8) || empty !== (model_count() == 0)) begin bad++; $display("FAIL rand_flags cyc=%0d: got full=%b empty=%b for count %0d", cyc, full, empty, model_count()); end
            for (int s = 0; s < 8; s++) begin
                total++; if (outs[s] !== md[s]) begin bad++; $display("FAIL rand_data cyc=%0d slot=%0d: got %h expected %h", cyc, s, outs[s], md[s]); end
            end
        end
        in_valid = 1'b0; out_ack = 8'h00;
    endtask

    initial begin
        mv = 8'h00;
        for (int i = 0; i < 8; i++) md[i] = '0;
        test_reset();
        test_fill();
        test_drain_refill();
        test_multi_ack();
        test_idle_ack();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
